// File: rtl/conv_0_1_mac_acc.sv
// ============================================================================
// conv_0_1_mac_acc
//
// Sums one kernel window of signed products from the conv_0_1 multiplier
// stage. The window's bias is added on the first accepted beat. The final sum
// is arithmetic-right-shifted by SHIFT, saturated to OUT_WIDTH bits and
// optionally clamped at zero (RELU). The pixel is then presented on a
// valid/ready output stream.
//
// Handshake semantics (both streams):
//   A transfer happens on a rising edge where valid && ready are both high.
//   A producer must hold its data stable while valid is high and ready is
//   low. Neither ready output depends combinationally on the partner's valid.
//   in_ready depends only on the FSM state and ap_rst.
//   out_valid is a registered state decode.
//
// Ports:
//   ap_clk     in   single clock, rising-edge active
//   ap_rst     in   asynchronous active-high reset
//   in_data    in   [IN_WIDTH]   signed product
//   in_valid   in   in_data is valid
//   in_ready   out  block can accept a product this cycle (ACC state)
//   bias       in   [BIAS_WIDTH] signed bias, sampled on the window's first beat
//   win_clr    in   synchronous abort of the window in progress (ACC only)
//   out_data   out  [OUT_WIDTH]  signed result pixel
//   out_valid  out  out_data holds a result (HOLD state)
//   out_ready  in   downstream accepts out_data
// ============================================================================
module conv_0_1_mac_acc #(
    parameter int IN_WIDTH    = 24,
    parameter int BIAS_WIDTH  = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 16,
    parameter int KERNEL_SIZE = 9,
    parameter int SHIFT       = 8,
    parameter int RELU        = 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIAS_WIDTH-1:0] bias,
    input  logic                  win_clr,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    // A one-product kernel still needs a 1-bit counter to stay legal.
    localparam int CNT_W = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KERNEL_SIZE - 1);

    // Saturation bounds expressed in accumulator width so the compare is a
    // plain signed comparison against the shifted sum.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        ACC_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        ACC_WIDTH'(-(1 << (OUT_WIDTH - 1)));

    // FSM encoding
    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]                  state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [OUT_WIDTH-1:0]        out_data_q, out_data_d;

    logic                        beat_acc;
    logic                        is_first;
    logic                        is_last;
    logic signed [ACC_WIDTH-1:0] in_data_ext;
    logic signed [ACC_WIDTH-1:0] bias_ext;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic signed [ACC_WIDTH-1:0] sat_val;
    logic [OUT_WIDTH-1:0]        result;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    // ap_rst is included so in_ready is low for the whole reset assertion,
    // not just after the first edge.
    assign in_ready  = (state_q == ST_ACC) && !ap_rst;
    assign out_valid = (state_q == ST_HOLD);
    assign out_data  = out_data_q;

    assign beat_acc = in_valid && in_ready;
    assign is_first = (cnt_q == '0);
    assign is_last  = (cnt_q == CNT_LAST);

    // ------------------------------------------------------------------
    // Datapath: running sum and result function
    // ------------------------------------------------------------------
    // Sign-extending casts of the signed inputs into accumulator width.
    assign in_data_ext = ACC_WIDTH'($signed(in_data));
    assign bias_ext    = ACC_WIDTH'($signed(bias));

    // First beat of a window replaces the stale accumulator with bias.
    assign sum = is_first ? (bias_ext + in_data_ext) : (acc_q + in_data_ext);

    // >>> on a signed operand floors toward minus infinity.
    assign shifted = sum >>> SHIFT;

    always_comb begin
        sat_val = shifted;
        if (shifted > SAT_MAX) begin
            sat_val = SAT_MAX;
        end else if (shifted < SAT_MIN) begin
            sat_val = SAT_MIN;
        end
    end

    always_comb begin
        result = sat_val[OUT_WIDTH-1:0];
        if ((RELU != 0) && sat_val[ACC_WIDTH-1]) begin
            result = '0;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;

        case (state_q)
            ST_ACC: begin
                if (win_clr) begin
                    // Abort wins over a beat presented in the same cycle:
                    // the beat is consumed (in_ready is 1) but dropped.
                    cnt_d = '0;
                    acc_d = '0;
                end else if (beat_acc) begin
                    acc_d = sum;
                    if (is_last) begin
                        cnt_d      = '0;
                        out_data_d = result;
                        state_d    = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_HOLD: begin
                // win_clr is deliberately ignored here; the finished pixel
                // is always delivered.
                if (out_ready) begin
                    state_d = ST_ACC;
                end
            end

            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q    <= ST_ACC;
            cnt_q      <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_conv_0_1_mac_acc.sv
// ============================================================================
// tb_conv_0_1_mac_acc
//
// Directed bench for conv_0_1_mac_acc. Two instances with identical stimulus
// are used: dut_r has RELU=1 and dut_l has RELU=0. Both use SHIFT=8 and
// KERNEL_SIZE=9. Inputs change 1 time unit after the rising edge. Outputs are
// sampled at that same point.
// ============================================================================
module tb_conv_0_1_mac_acc;

    logic        ap_clk;
    logic        ap_rst;
    logic [23:0] in_data;
    logic        in_valid;
    logic [15:0] bias;
    logic        win_clr;
    logic        out_ready;

    logic        in_ready_r, out_valid_r;
    logic [15:0] out_data_r;
    logic        in_ready_l, out_valid_l;
    logic [15:0] out_data_l;

    int checks = 0;
    int errors = 0;

    conv_0_1_mac_acc #(
        .IN_WIDTH(24), .BIAS_WIDTH(16), .ACC_WIDTH(32), .OUT_WIDTH(16),
        .KERNEL_SIZE(9), .SHIFT(8), .RELU(1)
    ) dut_r (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_r),
        .bias(bias), .win_clr(win_clr),
        .out_data(out_data_r), .out_valid(out_valid_r), .out_ready(out_ready)
    );

    conv_0_1_mac_acc #(
        .IN_WIDTH(24), .BIAS_WIDTH(16), .ACC_WIDTH(32), .OUT_WIDTH(16),
        .KERNEL_SIZE(9), .SHIFT(8), .RELU(0)
    ) dut_l (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
        .bias(bias), .win_clr(win_clr),
        .out_data(out_data_l), .out_valid(out_valid_l), .out_ready(out_ready)
    );

    // Clock
    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // ------------------------------------------------------------------
    // Check and driver tasks
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic send_beat(input logic [23:0] d, input logic [15:0] b);
        in_valid = 1'b1;
        in_data  = d;
        bias     = b;
        step();
        in_valid = 1'b0;
    endtask

    // Nine back-to-back beats. Checks that no result appears early and that
    // the result appears on the edge that accepts beat 9.
    task automatic run_window(input string tag, input logic [23:0] d,
                              input logic [15:0] b);
        for (int i = 0; i < 9; i++) begin
            send_beat(d, b);
            if (i == 7) chk({tag, "_early_valid"}, 32'(out_valid_r), 32'd0);
        end
        chk({tag, "_valid"}, 32'(out_valid_r), 32'd1);
        chk({tag, "_hold_ready"}, 32'(in_ready_r), 32'd0);
    endtask

    task automatic expect_pair(input string tag, input logic [15:0] exp_r,
                               input logic [15:0] exp_l);
        chk({tag, "_relu"}, 32'(out_data_r), 32'(exp_r));
        chk({tag, "_lin"},  32'(out_data_l), 32'(exp_l));
    endtask

    // Completes the handshake; out_ready is expected high on entry.
    task automatic drain(input string tag);
        step();
        chk({tag, "_drained"}, 32'(out_valid_r), 32'd0);
        chk({tag, "_ready_back"}, 32'(in_ready_l), 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        ap_rst    = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        bias      = '0;
        win_clr   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_in_ready", 32'(in_ready_r), 32'd0);
        chk("rst_out_valid", 32'(out_valid_r), 32'd0);
        chk("rst_out_data", 32'(out_data_l), 32'd0);
        step();
        step();
        ap_rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready_r), 32'd1);
        step();

        // Basic window: 9 * 256 = 2304, >>8 = 9
        run_window("basic", 24'd256, 16'd0);
        expect_pair("basic", 16'd9, 16'd9);
        drain("basic");

        // Bias only: 1000 >>8 = 3
        run_window("bias_pos", 24'd0, 16'd1000);
        expect_pair("bias_pos", 16'd3, 16'd3);
        drain("bias_pos");

        // Negative bias: -1000 >>8 = -4 (floor), ReLU gives 0
        run_window("bias_neg", 24'd0, 16'hFC18);
        expect_pair("bias_neg", 16'd0, 16'hFFFC);
        drain("bias_neg");

        // 9 * -512 = -4608, >>8 = -18
        run_window("neg_prod", 24'hFFFE00, 16'd0);
        expect_pair("neg_prod", 16'd0, 16'hFFEE);
        drain("neg_prod");

        // 9 * 8388607 = 75497463, >>8 = 294911, saturates to 0x7FFF
        run_window("sat_pos", 24'h7FFFFF, 16'd0);
        expect_pair("sat_pos", 16'h7FFF, 16'h7FFF);
        drain("sat_pos");

        // 9 * -8388608 = -75497472, >>8 = -294912, saturates to 0x8000
        run_window("sat_neg", 24'h800000, 16'd0);
        expect_pair("sat_neg", 16'd0, 16'h8000);
        drain("sat_neg");

        // Random bubbles: bias 512 + 9*256 = 2816, >>8 = 11
        for (int i = 0; i < 9; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                in_data = 24'hABCDEF; // must be ignored while in_valid=0
                step();
                chk("bubble_no_valid", 32'(out_valid_r), 32'd0);
            end
            send_beat(24'd256, 16'd512);
        end
        chk("bubble_valid", 32'(out_valid_r), 32'd1);
        expect_pair("bubble", 16'd11, 16'd11);
        drain("bubble");

        // HOLD stall: out_ready low for 5 cycles while junk is offered
        out_ready = 1'b0;
        run_window("stall", 24'd256, 16'd0);
        in_valid = 1'b1;
        in_data  = 24'h7FFFFF;
        win_clr  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", 32'(out_valid_l), 32'd1);
            chk("stall_data", 32'(out_data_l), 32'd9);
            chk("stall_in_ready", 32'(in_ready_l), 32'd0);
        end
        in_valid  = 1'b0;
        win_clr   = 1'b0;
        out_ready = 1'b1;
        chk("stall_data_final", 32'(out_data_r), 32'd9);
        drain("stall");
        run_window("after_stall", 24'd256, 16'd0);
        expect_pair("after_stall", 16'd9, 16'd9);
        drain("after_stall");

        // Abort: 4 beats of 1000, win_clr with a beat presented, then 9*256
        for (int i = 0; i < 4; i++) send_beat(24'd1000, 16'd100);
        win_clr  = 1'b1;
        in_valid = 1'b1;
        in_data  = 24'd5000;
        #1;
        chk("clr_in_ready", 32'(in_ready_r), 32'd1);
        step();
        win_clr  = 1'b0;
        in_valid = 1'b0;
        run_window("after_clr", 24'd256, 16'd0);
        expect_pair("after_clr", 16'd9, 16'd9);
        drain("after_clr");

        // Reset mid-window: asserted off the clock edge
        for (int i = 0; i < 4; i++) send_beat(24'd1000, 16'd100);
        #2;
        ap_rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready_r), 32'd0);
        chk("midrst_out_valid", 32'(out_valid_r), 32'd0);
        chk("midrst_out_data", 32'(out_data_l), 32'd0);
        step();
        ap_rst = 1'b0;
        step();
        run_window("after_rst", 24'd256, 16'd0);
        expect_pair("after_rst", 16'd9, 16'd9);

        // Reset during HOLD drops the pending pixel
        out_ready = 1'b0;
        step();
        ap_rst = 1'b1;
        #1;
        chk("holdrst_out_valid", 32'(out_valid_l), 32'd0);
        chk("holdrst_out_data", 32'(out_data_l), 32'd0);
        step();
        ap_rst    = 1'b0;
        out_ready = 1'b1;
        step();
        run_window("after_holdrst", 24'hFFFE00, 16'd0);
        expect_pair("after_holdrst", 16'd0, 16'hFFEE);
        drain("after_holdrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_0_1_mac_acc.md
# conv_0_1_mac_acc

Accumulates the stream of signed 24-bit products coming out of the conv_0_1 multiplier stage over one kernel window of KERNEL_SIZE products. It adds a per-window bias, rescales by an arithmetic right shift, saturates to 16 bits and applies optional ReLU. The result is emitted as one output pixel on a valid/ready stream. It sits directly downstream of the multiplier and upstream of the layer's output buffer.

## Interface
- IN_WIDTH, 24: width of the signed product input.
- BIAS_WIDTH, 16: width of the signed bias.
- ACC_WIDTH, 32: width of the signed accumulator.
- OUT_WIDTH, 16: width of the signed output pixel.
- KERNEL_SIZE, 9: number of products per window; must be at least 1.
- SHIFT, 8: arithmetic right shift applied before saturation; range 0..ACC_WIDTH-1.
- RELU, 1: 1 clamps negative results to 0; 0 passes them through.

Ports:
- ap_clk  in  1  the block's single clock; all state updates on the rising edge.
- ap_rst  in  1  reset, asynchronous and active-high.
- in_data  in  IN_WIDTH  signed product from the multiplier.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- bias  in  BIAS_WIDTH  signed bias, sampled on the first accepted beat of each window.
- win_clr  in  1  synchronous abort of the window in progress.
- out_data  out  OUT_WIDTH  signed result pixel.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  downstream accepts out_data.

## Operation
- A beat is accepted when in_valid && in_ready.
- States:
  - ACC: reset state. in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Counter cnt runs 0..KERNEL_SIZE-1 and advances only on an accepted beat. Bubbles (in_valid=0) change nothing.
- Accepted beat with cnt==0: acc <= sext(bias) + sext(in_data).
- Accepted beat with cnt>0: acc <= acc + sext(in_data).
- Accepted beat with cnt==KERNEL_SIZE-1:
  - out_data <= f(final sum).
  - cnt <= 0.
  - state -> HOLD.
- The result function f(s):
  - r = s >>> SHIFT, rounding toward minus infinity.
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - If RELU=1 and the saturated value is negative, the output is 0.
- The accumulator uses ACC_WIDTH arithmetic with no internal saturation. Sizing the parameters so the sum cannot overflow is the integrator's responsibility.
- HOLD: out_data stays stable until out_valid && out_ready, then state -> ACC. No input is accepted in HOLD.
- win_clr in ACC: cnt <= 0 and the partial sum is discarded. A beat accepted in the same cycle is dropped, and in_ready stays 1.
- win_clr in HOLD: ignored. The pending result is still delivered.
- KERNEL_SIZE=1: every accepted beat completes a window.

## Timing
- Reset values, asserted asynchronously while ap_rst=1:
  - state=ACC, cnt=0, acc=0.
  - out_data=0, out_valid=0.
  - in_ready=0 while ap_rst is high; in_ready=1 from the first cycle after deassertion.
- Latency: out_valid rises on the rising edge that accepts the last beat, one cycle after that beat is presented.
- Throughput: one window per KERNEL_SIZE+1 cycles at best. A HOLD lasting N cycles adds N-1 cycles.
- A handshake in HOLD returns to ACC on that edge. A new beat can be accepted on the next cycle.
- Reset mid-window or mid-HOLD discards everything. The first window after reset starts at cnt=0 with a fresh bias sample.
- No combinational path from in_valid to in_ready or from out_ready to out_valid. in_ready is a pure function of state and ap_rst.

## Test plan
- Basic window (SHIFT=8, RELU=1): nine products of 256, bias=0 -> sum 2304 -> out_data=9. out_valid asserts on the edge accepting beat 9. One HOLD cycle with out_ready=1.
- Bias and truncation: nine products of 0, bias=1000 -> out_data=3. Bias=-1000, RELU=0 -> out_data=-4 (0xFFFC).
- ReLU and sign:
  - Nine products of -512, bias=0 -> 0 with RELU=1.
  - Same stimulus -> -18 (0xFFEE) with RELU=0.
- Saturation (RELU=0):
  - Nine products of 8388607 -> 0x7FFF.
  - Nine products of -8388608 -> 0x8000.
- Flow control:
  - Random in_valid bubbles: count advances only on accepted beats, result identical to gap-free.
  - out_ready low 5 cycles in HOLD: out_valid held, out_data stable, in_ready=0, next window unaffected.
- Abort and reset:
  - win_clr after 4 beats, then nine beats of 256 -> 9.
  - ap_rst pulse mid-window after 4 beats -> all outputs 0. The next nine beats of 256 give 9.
